// File: rtl/mem_stage_pkg.sv
// Shared defines: ALU op codes, memory op codes and MEM FSM states.
package mem_stage_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_op_e;

    typedef enum logic [3:0] {
        MEM_NONE = 4'd0,
        MEM_LB   = 4'd1,
        MEM_LH   = 4'd2,
        MEM_LW   = 4'd3,
        MEM_LBU  = 4'd4,
        MEM_LHU  = 4'd5,
        MEM_SB   = 4'd6,
        MEM_SH   = 4'd7,
        MEM_SW   = 4'd8
    } memop_e;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAIT_GNT = 3'd1,
        S_XFER     = 3'd2,
        S_LAST     = 3'd3,
        S_DONE     = 3'd4
    } mem_state_e;

    function automatic logic op_is_load(logic [3:0] op);
        return op inside {MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU};
    endfunction

    function automatic logic op_is_store(logic [3:0] op);
        return op inside {MEM_SB, MEM_SH, MEM_SW};
    endfunction

    // Index of the final byte of the access (N-1).
    function automatic logic [1:0] op_last_idx(logic [3:0] op);
        if (op inside {MEM_LB, MEM_LBU, MEM_SB})
            return 2'd0;
        if (op inside {MEM_LH, MEM_LHU, MEM_SH})
            return 2'd1;
        return 2'd3;
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Shared 8-bit RAM port, arbitrated by grant.
interface mem_stage_if;
    logic        mem_req;
    logic [31:0] mem_a;
    logic [7:0]  mem_dout;
    logic        mem_wr;
    logic        mem_gnt;
    logic [7:0]  mem_din;

    modport master (
        output mem_req, mem_a, mem_dout, mem_wr,
        input  mem_gnt, mem_din
    );

    modport slave (
        input  mem_req, mem_a, mem_dout, mem_wr,
        output mem_gnt, mem_din
    );
endinterface

// File: rtl/mem_ext.sv
// Load sign/zero extension of the assembled load bytes.
module mem_ext
    import mem_stage_pkg::*;
(
    input  logic [3:0]  memop,
    input  logic [31:0] raw,
    output logic [31:0] ext
);

    always_comb begin
        ext = raw;
        unique case (memop)
            MEM_LB:  ext = {{24{raw[7]}}, raw[7:0]};
            MEM_LBU: ext = {24'h0, raw[7:0]};
            MEM_LH:  ext = {{16{raw[15]}}, raw[15:0]};
            MEM_LHU: ext = {16'h0, raw[15:0]};
            default: ext = raw;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: byte-serial loads/stores over a shared 8-bit RAM port.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  ex_memop,
    input  logic [31:0] ex_addr,
    input  logic [31:0] ex_sdata,
    input  logic [4:0]  ex_wd,
    input  logic        ex_wreg,
    input  logic [31:0] ex_wdata,
    mem_stage_if.master mem,
    output logic [4:0]  wb_wd,
    output logic        wb_wreg,
    output logic [31:0] wb_wdata,
    output logic        stall_req
);

    mem_state_e  state, state_nx;
    logic [1:0]  cnt, cnt_nx;
    logic [1:0]  cnt_m1;
    logic [1:0]  last_idx;
    logic [31:0] result, result_nx;
    logic [31:0] ld_val;
    logic        is_ld, is_st;

    assign is_ld    = op_is_load(ex_memop);
    assign is_st    = op_is_store(ex_memop);
    assign last_idx = op_last_idx(ex_memop);
    assign cnt_m1   = cnt - 2'd1;

    mem_ext u_ext (
        .memop (ex_memop),
        .raw   (result),
        .ext   (ld_val)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            cnt    <= 2'd0;
            result <= 32'h0;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            result <= result_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        cnt_nx       = cnt;
        result_nx    = result;
        mem.mem_req  = 1'b0;
        mem.mem_a    = 32'h0;
        mem.mem_dout = 8'h0;
        mem.mem_wr   = 1'b0;
        stall_req    = 1'b0;
        wb_wd        = 5'h0;
        wb_wreg      = 1'b0;
        wb_wdata     = 32'h0;

        unique case (state)
            S_IDLE: begin
                if (is_ld || is_st) begin
                    mem.mem_req = 1'b1;
                    stall_req   = 1'b1;
                    cnt_nx      = 2'd0;
                    result_nx   = 32'h0;
                    state_nx    = mem.mem_gnt ? S_XFER : S_WAIT_GNT;
                end else begin
                    wb_wd    = ex_wd;
                    wb_wreg  = ex_wreg;
                    wb_wdata = ex_wdata;
                end
            end
            S_WAIT_GNT: begin
                mem.mem_req = 1'b1;
                stall_req   = 1'b1;
                if (mem.mem_gnt)
                    state_nx = S_XFER;
            end
            S_XFER: begin
                mem.mem_req = 1'b1;
                stall_req   = 1'b1;
                mem.mem_a   = ex_addr + {30'h0, cnt};
                if (is_st) begin
                    mem.mem_wr   = 1'b1;
                    mem.mem_dout = ex_sdata[{cnt, 3'b000} +: 8];
                end else if (cnt != 2'd0) begin
                    // RAM data lags the address by one cycle.
                    result_nx[{cnt_m1, 3'b000} +: 8] = mem.mem_din;
                end
                if (cnt == last_idx) begin
                    cnt_nx   = 2'd0;
                    state_nx = is_st ? S_DONE : S_LAST;
                end else begin
                    cnt_nx = cnt + 2'd1;
                end
            end
            S_LAST: begin
                mem.mem_req = 1'b1;
                stall_req   = 1'b1;
                result_nx[{last_idx, 3'b000} +: 8] = mem.mem_din;
                state_nx = S_DONE;
            end
            S_DONE: begin
                wb_wd    = ex_wd;
                wb_wreg  = ex_wreg;
                wb_wdata = is_ld ? ld_val : ex_wdata;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase

        if (rst) begin
            mem.mem_req  = 1'b0;
            mem.mem_a    = 32'h0;
            mem.mem_dout = 8'h0;
            mem.mem_wr   = 1'b0;
            stall_req    = 1'b0;
            wb_wd        = 5'h0;
            wb_wreg      = 1'b0;
            wb_wdata     = 32'h0;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage with a byte RAM, delayed-grant arbiter
// and a transaction-level reference model.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  ex_memop;
    logic [31:0] ex_addr, ex_sdata, ex_wdata;
    logic [4:0]  ex_wd;
    logic        ex_wreg;
    logic [4:0]  wb_wd;
    logic        wb_wreg;
    logic [31:0] wb_wdata;
    logic        stall_req;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_stage_if mif ();

    mem_stage dut (
        .clk       (clk),
        .rst       (rst),
        .ex_memop  (ex_memop),
        .ex_addr   (ex_addr),
        .ex_sdata  (ex_sdata),
        .ex_wd     (ex_wd),
        .ex_wreg   (ex_wreg),
        .ex_wdata  (ex_wdata),
        .mem       (mif),
        .wb_wd     (wb_wd),
        .wb_wreg   (wb_wreg),
        .wb_wdata  (wb_wdata),
        .stall_req (stall_req)
    );

    // Environment: byte RAM and an arbiter granting after gnt_delay request cycles
    logic [7:0] ram [bit [31:0]];
    logic [7:0] ref_mem [bit [31:0]];
    int gnt_delay = 0;
    int wcnt = 0;

    always @(posedge clk) begin
        if (mif.mem_wr)
            ram[mif.mem_a] = mif.mem_dout;
        mif.mem_din <= ram.exists(mif.mem_a) ? ram[mif.mem_a] : 8'h00;
        wcnt <= mif.mem_req ? wcnt + 1 : 0;
    end

    assign mif.mem_gnt = (wcnt >= gnt_delay);

    function automatic logic [7:0] rd_ram(logic [31:0] a);
        return ram.exists(a) ? ram[a] : 8'h00;
    endfunction

    function automatic logic [7:0] rd_ref(logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
    endfunction

    task automatic poke(input logic [31:0] a, input logic [7:0] d);
        ram[a]     = d;
        ref_mem[a] = d;
    endtask

    // Reference model
    function automatic int ref_nbytes(logic [3:0] op);
        case (op)
            MEM_LB, MEM_LBU, MEM_SB: return 1;
            MEM_LH, MEM_LHU, MEM_SH: return 2;
            MEM_LW, MEM_SW:          return 4;
            default:                 return 0;
        endcase
    endfunction

    function automatic bit ref_is_store(logic [3:0] op);
        return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
    endfunction

    function automatic logic [31:0] ref_load(logic [3:0] op, logic [31:0] a);
        logic [31:0] v;
        v = 32'h0;
        for (int k = 0; k < ref_nbytes(op); k++)
            v = v + ({24'h0, rd_ref(a + 32'(k))} << (8 * k));
        if (op == MEM_LB && v >= 32'd128)
            v = v + 32'hFFFFFF00;
        if (op == MEM_LH && v >= 32'd32768)
            v = v + 32'hFFFF0000;
        return v;
    endfunction

    // Drives one op starting at posedge+1 and checks every cycle until writeback
    task automatic mem_txn(input logic [3:0] op, input logic [31:0] addr,
                           input logic [31:0] sdata, input logic [31:0] wdata,
                           input logic [4:0] wd, input logic wreg,
                           input int delay, input string name);
        int n, total, xs, k;
        bit ld, st;
        logic [31:0] ev;
        logic [80:0] exp_v, got_v;
        n  = ref_nbytes(op);
        st = ref_is_store(op);
        ld = (n > 0) && !st;
        ev = ld ? ref_load(op, addr) : wdata;
        if (st)
            for (int i = 0; i < n; i++)
                ref_mem[addr + 32'(i)] = 8'(sdata >> (8 * i));
        total = (n == 0) ? 1 : delay + 1 + n + (ld ? 1 : 0) + 1;
        xs = delay + 1;
        gnt_delay = delay;
        ex_memop = op;
        ex_addr  = addr;
        ex_sdata = sdata;
        ex_wdata = wdata;
        ex_wd    = wd;
        ex_wreg  = wreg;
        for (int c = 0; c < total; c++) begin
            @(negedge clk);
            k = c - xs;
            if (n == 0)
                exp_v = {3'b000, 32'h0, 8'h0, wreg, wd, wdata};
            else if (c == total - 1)
                exp_v = {3'b000, 32'h0, 8'h0, wreg, wd, ev};
            else if (c >= xs && k < n)
                exp_v = {1'b1, 1'b1, st, addr + 32'(k),
                         st ? 8'(sdata >> (8 * k)) : 8'h0, 1'b0, 5'h0, 32'h0};
            else
                exp_v = {1'b1, 1'b1, 1'b0, 32'h0, 8'h0, 1'b0, 5'h0, 32'h0};
            got_v = {mif.mem_req, stall_req, mif.mem_wr, mif.mem_a, mif.mem_dout,
                     wb_wreg, wb_wd, wb_wdata};
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL %s cycle %0d: got %h expected %h (req,stall,wr,a,dout,wreg,wd,wdata)",
                         name, c, got_v, exp_v);
            end
            @(posedge clk);
            #1;
        end
        ex_memop = MEM_NONE;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        ex_memop = MEM_LW;
        ex_addr  = 32'h1000;
        ex_sdata = 32'h0;
        ex_wdata = 32'h1234;
        ex_wd    = 5'd7;
        ex_wreg  = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({mif.mem_req, mif.mem_wr, stall_req, wb_wreg, wb_wd, wb_wdata} !== 40'h0) begin
            errors++;
            $display("FAIL reset: req=%b wr=%b stall=%b wreg=%b wd=%h wdata=%h required all 0",
                     mif.mem_req, mif.mem_wr, stall_req, wb_wreg, wb_wd, wb_wdata);
        end
        @(posedge clk);
        #1;
        ex_memop = MEM_NONE;
        rst = 1'b0;
    endtask

    task automatic test_alu;
        mem_txn(MEM_NONE, 32'h0, 32'h0, 32'h55, 5'd3, 1'b1, 0, "alu_op");
        for (int i = 0; i < 4; i++)
            mem_txn(4'(9 + $urandom_range(0, 6)), $urandom, $urandom, $urandom,
                    5'($urandom), 1'($urandom), 0, "invalid_op");
    endtask

    task automatic test_loads;
        poke(32'h1000, 8'h78);
        poke(32'h1001, 8'h56);
        poke(32'h1002, 8'h34);
        poke(32'h1003, 8'h12);
        mem_txn(MEM_LW, 32'h1000, 32'h0, 32'h0, 5'd5, 1'b1, 0, "lw_1000");
        checks++;
        if (ref_load(MEM_LW, 32'h1000) !== 32'h12345678) begin
            errors++;
            $display("FAIL lw_model: got %h required 12345678", ref_load(MEM_LW, 32'h1000));
        end
        poke(32'h3, 8'h80);
        mem_txn(MEM_LB, 32'h3, 32'h0, 32'h0, 5'd6, 1'b1, 0, "lb_sext");
        mem_txn(MEM_LBU, 32'h3, 32'h0, 32'h0, 5'd6, 1'b1, 0, "lbu_zext");
        poke(32'hFFFFFFFF, 8'h34);
        poke(32'h0, 8'h82);
        mem_txn(MEM_LH, 32'hFFFFFFFF, 32'h0, 32'h0, 5'd8, 1'b1, 1, "lh_wrap");
        mem_txn(MEM_LHU, 32'hFFFFFFFF, 32'h0, 32'h0, 5'd9, 1'b1, 2, "lhu_wrap");
    endtask

    task automatic test_store;
        poke(32'h2004, 8'h11);
        mem_txn(MEM_SW, 32'h2000, 32'hDEADBEEF, 32'hCAFE, 5'd0, 1'b0, 3, "sw_2000");
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (rd_ram(32'h2000 + 32'(k)) !== rd_ref(32'h2000 + 32'(k))) begin
                errors++;
                $display("FAIL sw_ram[%0d]: got %h required %h", k,
                         rd_ram(32'h2000 + 32'(k)), rd_ref(32'h2000 + 32'(k)));
            end
        end
    endtask

    task automatic test_reset_mid;
        poke(32'h1000, 8'h78);
        gnt_delay = 0;
        ex_memop = MEM_LW;
        ex_addr  = 32'h1000;
        ex_wd    = 5'd4;
        ex_wreg  = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (mif.mem_a !== 32'h1002 || stall_req !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_pre: a=%h stall=%b required a=1002 stall=1", mif.mem_a, stall_req);
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({mif.mem_req, mif.mem_wr, stall_req, wb_wreg} !== 4'b0) begin
            errors++;
            $display("FAIL rst_mid: req=%b wr=%b stall=%b wreg=%b required 0",
                     mif.mem_req, mif.mem_wr, stall_req, wb_wreg);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        mem_txn(MEM_NONE, 32'h0, 32'h0, 32'hA5A5, 5'd2, 1'b1, 0, "rst_mid_idle");
        mem_txn(MEM_LW, 32'h1000, 32'h0, 32'h0, 5'd4, 1'b1, 0, "rst_mid_retry");
    endtask

    task automatic test_back_to_back;
        mem_txn(MEM_SB, 32'h3000, 32'h000000A5, 32'h77, 5'd1, 1'b0, 0, "b2b_sb");
        mem_txn(MEM_LW, 32'h3000, 32'h0, 32'h0, 5'd10, 1'b1, 0, "b2b_lw");
        mem_txn(MEM_SH, 32'h3001, 32'h0000BEEF, 32'h1, 5'd2, 1'b1, 1, "b2b_sh");
        mem_txn(MEM_LH, 32'h3001, 32'h0, 32'h0, 5'd11, 1'b1, 0, "b2b_lh");
    endtask

    task automatic test_random;
        logic [31:0] a;
        for (int i = 0; i < 150; i++) begin
            a = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 31))
                                            : 32'hFFFFFFF0 + 32'($urandom_range(0, 15));
            mem_txn(4'($urandom_range(0, 15)), a, $urandom, $urandom, 5'($urandom),
                    1'($urandom), $urandom_range(0, 3), "random");
        end
        foreach (ref_mem[a2]) begin
            checks++;
            if (rd_ram(a2) !== ref_mem[a2]) begin
                errors++;
                $display("FAIL ram_final[%h]: got %h required %h", a2, rd_ram(a2), ref_mem[a2]);
            end
        end
    endtask

    initial begin
        test_reset;
        test_alu;
        test_loads;
        test_store;
        test_reset_mid;
        test_back_to_back;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
